// File: rtl/port_tx.sv
// Transmit port: a small FIFO feeding a valid/ready link toward a switch
// downstream port, with optional idle gap cycles after every accepted transfer.
module port_tx #(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push_valid,
  input  logic [7:0]               push_addr,
  input  logic [7:0]               push_data,
  output logic                     push_rdy,
  input  logic                     flush,
  output logic [7:0]               addr_in,
  output logic [7:0]               data_in,
  output logic                     valid_in,
  input  logic                     rcv_rdy,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              tx_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    gap_cnt;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   head;
  logic          push_acc;
  logic          pop;
  logic          accept;

  assign push_rdy = (level < (AW+1)'(DEPTH));
  assign push_acc = push_valid && push_rdy && !flush;
  assign accept   = (state == ST_SEND) && rcv_rdy;
  // Pop only when the output registers are free this cycle: from IDLE, or
  // back-to-back out of SEND when no gap is configured.
  assign pop      = !flush && (level != '0) &&
                    ((state == ST_IDLE) || (accept && (GAP == 0)));
  assign head     = mem[rd_ptr];
  assign busy     = (level != '0) || (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= {push_addr, push_data};
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_acc, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state    <= ST_IDLE;
      valid_in <= 1'b0;
      addr_in  <= '0;
      data_in  <= '0;
      gap_cnt  <= '0;
      tx_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid_in <= 1'b0;
          if (pop) begin
            state    <= ST_SEND;
            valid_in <= 1'b1;
            addr_in  <= head[15:8];
            data_in  <= head[7:0];
          end
        end
        ST_SEND: begin
          if (accept) begin
            if (tx_count != '1) begin
              tx_count <= tx_count + 16'd1;
            end
            if (GAP != 0) begin
              state    <= ST_GAP;
              valid_in <= 1'b0;
              gap_cnt  <= 4'(GAP);
            end else if (pop) begin
              valid_in <= 1'b1;
              addr_in  <= head[15:8];
              data_in  <= head[7:0];
            end else begin
              state    <= ST_IDLE;
              valid_in <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          valid_in <= 1'b0;
          if (gap_cnt <= 4'd1) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          valid_in <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_tx.sv
// Directed bench for port_tx: vector table for basic flow, plus hand sequences
// for full FIFO, gap spacing, flush and asynchronous reset.
module tb_port_tx;

  logic       clk;
  logic       rst_b;
  logic       push_valid;
  logic [7:0] push_addr;
  logic [7:0] push_data;
  logic       flush;
  logic       rcv_rdy;

  logic       push_rdy, valid_in, busy;
  logic [7:0] addr_in, data_in;
  logic [2:0] level;
  logic [15:0] tx_count;

  logic       push_rdy2, valid2, busy2;
  logic [7:0] addr2, data2;
  logic [2:0] level2;
  logic [15:0] tx2;

  int total = 0;
  int bad   = 0;

  port_tx #(.DEPTH(4), .GAP(0)) dut0 (
    .clk(clk), .rst_b(rst_b), .push_valid(push_valid), .push_addr(push_addr),
    .push_data(push_data), .push_rdy(push_rdy), .flush(flush),
    .addr_in(addr_in), .data_in(data_in), .valid_in(valid_in),
    .rcv_rdy(rcv_rdy), .busy(busy), .level(level), .tx_count(tx_count)
  );

  port_tx #(.DEPTH(4), .GAP(2)) dut2 (
    .clk(clk), .rst_b(rst_b), .push_valid(push_valid), .push_addr(push_addr),
    .push_data(push_data), .push_rdy(push_rdy2), .flush(flush),
    .addr_in(addr2), .data_in(data2), .valid_in(valid2),
    .rcv_rdy(rcv_rdy), .busy(busy2), .level(level2), .tx_count(tx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pv;
    logic [7:0] pa;
    logic [7:0] pd;
    logic       rr;
    logic       ev;
    logic [7:0] ea;
    logic [7:0] ed;
    logic [2:0] el;
    logic       erdy;
    logic       ebusy;
    logic [15:0] etx;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic pv, input logic [7:0] pa, input logic [7:0] pd,
                              input logic rr, input logic ev, input logic [7:0] ea,
                              input logic [7:0] ed, input logic [2:0] el, input logic erdy,
                              input logic ebusy, input logic [15:0] etx);
    vec_t v;
    v.pv = pv; v.pa = pa; v.pd = pd; v.rr = rr; v.ev = ev; v.ea = ea; v.ed = ed;
    v.el = el; v.erdy = erdy; v.ebusy = ebusy; v.etx = etx;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b1;
    push_valid = 1'b0; push_addr = '0; push_data = '0; flush = 1'b0; rcv_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  logic [7:0] got [8];
  logic [8:0] pat;
  int n;

  initial begin
    // single entry, backpressure hold, then simultaneous push/pop streaming
    tbl[0]  = mk(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h00, 8'h00, 3'd1, 1'b1, 1'b1, 16'd0);
    tbl[1]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA5, 8'h3C, 3'd0, 1'b1, 1'b1, 16'd0);
    tbl[2]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 8'h3C, 3'd0, 1'b1, 1'b0, 16'd1);
    tbl[3]  = mk(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 8'hA5, 8'h3C, 3'd1, 1'b1, 1'b1, 16'd1);
    tbl[4]  = mk(1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 8'h11, 8'h22, 3'd1, 1'b1, 1'b1, 16'd1);
    tbl[5]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'h22, 3'd1, 1'b1, 1'b1, 16'd1);
    tbl[6]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'h22, 3'd1, 1'b1, 1'b1, 16'd1);
    tbl[7]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'h22, 3'd1, 1'b1, 1'b1, 16'd1);
    tbl[8]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'h22, 3'd1, 1'b1, 1'b1, 16'd1);
    tbl[9]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'h22, 3'd1, 1'b1, 1'b1, 16'd1);
    tbl[10] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h33, 8'h44, 3'd0, 1'b1, 1'b1, 16'd2);
    tbl[11] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 8'h44, 3'd0, 1'b1, 1'b0, 16'd3);
    tbl[12] = mk(1'b1, 8'h55, 8'h66, 1'b1, 1'b0, 8'h33, 8'h44, 3'd1, 1'b1, 1'b1, 16'd3);
    tbl[13] = mk(1'b1, 8'h77, 8'h88, 1'b1, 1'b1, 8'h55, 8'h66, 3'd1, 1'b1, 1'b1, 16'd3);
    tbl[14] = mk(1'b1, 8'h99, 8'hAA, 1'b1, 1'b1, 8'h77, 8'h88, 3'd1, 1'b1, 1'b1, 16'd4);
    tbl[15] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h99, 8'hAA, 3'd0, 1'b1, 1'b1, 16'd5);
    tbl[16] = mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h99, 8'hAA, 3'd0, 1'b1, 1'b0, 16'd6);

    rst_b = 1'b1;
    push_valid = 1'b0; push_addr = '0; push_data = '0; flush = 1'b0; rcv_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 16'(valid_in), 16'd0);
    chk("rst_addr", 16'(addr_in), 16'd0);
    chk("rst_level", 16'(level), 16'd0);
    chk("rst_push_rdy", 16'(push_rdy), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_tx", tx_count, 16'd0);
    rst_b = 1'b0;

    for (int i = 0; i < 17; i++) begin
      push_valid = tbl[i].pv; push_addr = tbl[i].pa; push_data = tbl[i].pd;
      rcv_rdy = tbl[i].rr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 16'(valid_in), 16'(tbl[i].ev));
      chk($sformatf("v%0d_addr", i), 16'(addr_in), 16'(tbl[i].ea));
      chk($sformatf("v%0d_data", i), 16'(data_in), 16'(tbl[i].ed));
      chk($sformatf("v%0d_level", i), 16'(level), 16'(tbl[i].el));
      chk($sformatf("v%0d_push_rdy", i), 16'(push_rdy), 16'(tbl[i].erdy));
      chk($sformatf("v%0d_busy", i), 16'(busy), 16'(tbl[i].ebusy));
      chk($sformatf("v%0d_tx", i), tx_count, tbl[i].etx);
      @(negedge clk);
    end

    // full FIFO: 6 pushes under backpressure, 5 survive (4 queued + 1 in flight)
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_valid = 1'b1; push_addr = 8'(8'h10 + k); push_data = 8'(8'h80 + k);
      @(posedge clk);
      #1;
      if (k == 4) begin
        chk("full_push_rdy", 16'(push_rdy), 16'd0);
        chk("full_level4", 16'(level), 16'd4);
      end
      @(negedge clk);
    end
    chk("full_level_after_drop", 16'(level), 16'd4);
    push_valid = 1'b0;
    rcv_rdy = 1'b1;
    n = 0;
    repeat (10) begin
      if (valid_in && n < 8) begin
        got[n] = addr_in;
        n++;
      end
      @(negedge clk);
    end
    chk("full_count", 16'(n), 16'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("full_order%0d", i), 16'(got[i]), 16'(8'h10 + i));
    end
    chk("full_tx", tx_count, 16'd5);

    // GAP=2 instance: valid pattern 1,0,0,0,1,0,0,0,1
    do_reset();
    rcv_rdy = 1'b1;
    pat = '0;
    for (int c = 0; c < 11; c++) begin
      if (c >= 2) pat = {pat[7:0], valid2};
      push_valid = (c < 3);
      push_addr = 8'(8'hC0 + c); push_data = 8'(8'hD0 + c);
      @(negedge clk);
    end
    push_valid = 1'b0;
    chk("gap_pattern", 16'(pat), 16'(9'b100010001));
    repeat (4) @(negedge clk);
    chk("gap_tx", tx2, 16'd3);
    chk("gap_busy", 16'(busy2), 16'd0);

    // flush with one entry in flight and three queued
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_valid = 1'b1; push_addr = 8'(8'h20 + k); push_data = 8'(8'h60 + k);
      @(negedge clk);
    end
    chk("flush_pre_level", 16'(level), 16'd3);
    flush = 1'b1; push_valid = 1'b1; push_addr = 8'hEE; push_data = 8'hEE;
    @(posedge clk);
    #1;
    chk("flush_level", 16'(level), 16'd0);
    chk("flush_inflight_valid", 16'(valid_in), 16'd1);
    chk("flush_inflight_addr", 16'(addr_in), 16'h20);
    @(negedge clk);
    flush = 1'b0; push_valid = 1'b0; rcv_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_delivered_valid", 16'(valid_in), 16'd0);
    chk("flush_tx", tx_count, 16'd1);
    repeat (3) @(negedge clk);
    chk("flush_tx_final", tx_count, 16'd1);
    chk("flush_busy", 16'(busy), 16'd0);

    // asynchronous reset in the middle of SEND
    do_reset();
    rcv_rdy = 1'b1; push_valid = 1'b1; push_addr = 8'h01; push_data = 8'h02;
    @(negedge clk);
    push_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ar_tx_before", tx_count, 16'd1);
    rcv_rdy = 1'b0; push_valid = 1'b1; push_addr = 8'h03; push_data = 8'h04;
    @(negedge clk);
    push_valid = 1'b0;
    @(negedge clk);
    chk("ar_send_valid", 16'(valid_in), 16'd1);
    #2;
    rst_b = 1'b1;
    #1;
    chk("ar_valid", 16'(valid_in), 16'd0);
    chk("ar_tx", tx_count, 16'd0);
    chk("ar_level", 16'(level), 16'd0);
    chk("ar_push_rdy", 16'(push_rdy), 16'd1);
    chk("ar_busy", 16'(busy), 16'd0);
    @(negedge clk);
    rst_b = 1'b0; push_valid = 1'b1; push_addr = 8'h42; push_data = 8'h43;
    @(posedge clk);
    #1;
    chk("ar_first_push", 16'(level), 16'd1);
    @(negedge clk);
    push_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
